// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target.
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_slave_state_t;
endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one asynchronous bus line and flags its edges.
// Level and edge pulses appear STAGES clk after the pin changes; the FSM registers them one clk later.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    // chain[STAGES-1:0] is the synchronizer, chain[STAGES] holds the previous level
    logic [STAGES:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-1:0], din};
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~chain[STAGES];
    assign fall  = ~chain[STAGES-1] & chain[STAGES];
endmodule

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address: receives written bytes, returns tx_data on reads.
// Bus events act SYNC_STAGES+1 clk after the pins move; clock stretching is not used.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  rw,
    output logic                  busy
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (scl_i),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sda_i),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    i2c_slave_state_t      state, state_nxt;
    logic [3:0]            bit_cnt, bit_cnt_nxt;
    logic [I2C_BYTE_W-1:0] shreg, shreg_nxt;
    logic [I2C_BYTE_W-1:0] rx_data_nxt;
    logic                  sda_oe_nxt, rx_pend, rx_pend_nxt, rx_valid_nxt;
    logic                  tx_req_nxt, rw_nxt, busy_nxt;
    logic                  start_det, stop_det;

    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_pend  <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            sda_oe   <= sda_oe_nxt;
            rx_data  <= rx_data_nxt;
            rx_pend  <= rx_pend_nxt;
            rx_valid <= rx_valid_nxt;
            tx_req   <= tx_req_nxt;
            rw       <= rw_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        sda_oe_nxt   = sda_oe;
        rx_data_nxt  = rx_data;
        rx_pend_nxt  = 1'b0;
        rx_valid_nxt = rx_pend;
        tx_req_nxt   = 1'b0;
        rw_nxt       = rw;
        busy_nxt     = busy;

        // START outranks STOP and any SCL edge seen in the same cycle
        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[I2C_BYTE_W-2:0], sda_lvl};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (shreg[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                            state_nxt  = ADDR_ACK;
                            sda_oe_nxt = 1'b1;
                            busy_nxt   = 1'b1;
                            rw_nxt     = shreg[0];
                        end else begin
                            state_nxt  = IGNORE;
                            sda_oe_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise) begin
                        tx_req_nxt = rw;
                    end else if (scl_fall) begin
                        bit_cnt_nxt = '0;
                        if (rw) begin
                            state_nxt  = READ;
                            shreg_nxt  = tx_data;
                            sda_oe_nxt = ~tx_data[I2C_BYTE_W-1];
                        end else begin
                            state_nxt  = WRITE;
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[I2C_BYTE_W-2:0], sda_lvl};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_data_nxt = {shreg[I2C_BYTE_W-2:0], sda_lvl};
                            rx_pend_nxt = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nxt   = WRITE_ACK;
                        sda_oe_nxt  = 1'b1;
                        bit_cnt_nxt = '0;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        state_nxt  = WRITE;
                        sda_oe_nxt = 1'b0;
                    end
                end
                READ: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt  = READ_ACK;
                            sda_oe_nxt = 1'b0;
                        end else if (bit_cnt != 4'd0) begin
                            shreg_nxt  = {shreg[I2C_BYTE_W-2:0], 1'b0};
                            sda_oe_nxt = ~shreg[I2C_BYTE_W-2];
                        end
                    end
                end
                READ_ACK: begin
                    // a fall here is only reachable after the controller ACKed
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            tx_req_nxt = 1'b1;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end else if (scl_fall) begin
                        state_nxt   = READ;
                        bit_cnt_nxt = '0;
                        shreg_nxt   = tx_data;
                        sda_oe_nxt  = ~tx_data[I2C_BYTE_W-1];
                    end
                end
                default: begin
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged controller on a wired-AND SDA, transaction-level expectations.
module tb_i2c_slave;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe, rx_valid, tx_req, rw, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq [$];
    logic [7:0] tx_tab [8];
    int         tx_base = 0;
    int         txreq_cnt = 0;
    int         busy_low_cnt = 0;

    always #5 clk = ~clk;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_i    (scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rw       (rw),
        .busy     (busy)
    );

    // Application side: record received bytes, serve the next table entry per tx_req
    always @(negedge clk) begin
        if (!reset_n) begin
            tx_data = 8'h00;
        end else begin
            if (rx_valid) rxq.push_back(rx_data);
            if (tx_req) begin
                tx_data = tx_tab[(txreq_cnt - tx_base) & 7];
                txreq_cnt++;
            end
            if (!busy) busy_low_cnt++;
        end
    end

    initial begin
        #800000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_bit(input logic b, output logic obs);
        sda_drv = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        obs = sda_bus;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic start_c();
        sda_drv = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_drv = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic stop_c();
        sda_drv = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_drv = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic o;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], o);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_it, output logic [7:0] b);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, o);
            b[i] = o;
        end
        bus_bit(~ack_it, o);
    endtask

    task automatic run_write(input logic [6:0] a, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic do_stop);
        logic [7:0] d [4];
        logic       ack, match;
        int         rb;
        match = (a == 7'h50);
        rb = rxq.size();
        for (int i = 0; i < 4; i++) d[i] = (i == 0) ? b0 : (i == 1) ? b1 : 8'($urandom);
        start_c();
        send_byte({a, 1'b0}, ack);
        chk("wr_addr_ack", 32'(ack), 32'(!match));
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], ack);
            chk("wr_data_ack", 32'(ack), 32'(!match));
        end
        if (do_stop) stop_c();
        chk("rx_count", 32'(rxq.size() - rb), match ? 32'(n) : 32'd0);
        if (match) begin
            for (int i = 0; i < n; i++) chk("rx_byte", 32'(rxq[rb + i]), 32'(d[i]));
        end
    endtask

    task automatic run_read(input logic [6:0] a, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic do_stop);
        logic       ack, match;
        logic [7:0] b;
        match = (a == 7'h50);
        for (int i = 0; i < 8; i++) tx_tab[i] = (i == 0) ? b0 : (i == 1) ? b1 : 8'($urandom);
        tx_base = txreq_cnt;
        start_c();
        send_byte({a, 1'b1}, ack);
        chk("rd_addr_ack", 32'(ack), 32'(!match));
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, b);
            chk("rd_byte", 32'(b), match ? 32'(tx_tab[i]) : 32'hFF);
        end
        chk("tx_req_count", 32'(txreq_cnt - tx_base), match ? 32'(n) : 32'd0);
        if (do_stop) stop_c();
    endtask

    initial begin
        logic       ack, o, rd;
        logic [6:0] a;
        int         rb, bl, n;

        // reset state
        wait_clk(4);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_rw", 32'(rw), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        wait_clk(Q);

        // write two bytes, then STOP
        run_write(7'h50, 2, 8'hA5, 8'h3C, 1'b1);
        chk("wr_rw", 32'(rw), 32'd0);
        chk("wr_busy_after_stop", 32'(busy), 32'd0);

        // read two bytes: ACK the first, NACK the second
        run_read(7'h50, 2, 8'h96, 8'h0F, 1'b0);
        chk("rd_rw", 32'(rw), 32'd1);
        chk("rd_busy_before_stop", 32'(busy), 32'd1);
        chk("rd_oe_after_nack", 32'(sda_oe), 32'd0);
        stop_c();
        chk("rd_busy_after_stop", 32'(busy), 32'd0);

        // foreign address is never acknowledged
        rb = rxq.size();
        run_write(7'h51, 1, 8'h77, 8'h00, 1'b0);
        chk("nomatch_busy", 32'(busy), 32'd0);
        chk("nomatch_oe", 32'(sda_oe), 32'd0);
        stop_c();
        chk("nomatch_rx", 32'(rxq.size() - rb), 32'd0);

        // write, repeated START, read: busy must not drop in between
        run_write(7'h50, 1, 8'h12, 8'h00, 1'b0);
        bl = busy_low_cnt;
        run_read(7'h50, 1, 8'hC3, 8'h00, 1'b0);
        chk("rs_busy_held", 32'(busy_low_cnt - bl), 32'd0);
        chk("rs_rx_data", 32'(rx_data), 32'h12);
        chk("rs_rw", 32'(rw), 32'd1);
        stop_c();
        chk("rs_busy_after_stop", 32'(busy), 32'd0);

        // STOP after four data bits discards the partial byte
        rb = rxq.size();
        start_c();
        send_byte({7'h50, 1'b0}, ack);
        chk("part_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) bus_bit(1'(i & 1), o);
        stop_c();
        wait_clk(Q);
        chk("part_rx", 32'(rxq.size() - rb), 32'd0);
        chk("part_oe", 32'(sda_oe), 32'd0);
        chk("part_busy", 32'(busy), 32'd0);

        // reset asserted while the target is driving a read bit low
        tx_tab[0] = 8'h00;
        tx_base = txreq_cnt;
        start_c();
        send_byte({7'h50, 1'b1}, ack);
        chk("rr_addr_ack", 32'(ack), 32'd0);
        chk("rr_oe_driving", 32'(sda_oe), 32'd1);
        sda_drv = 1'b1;
        reset_n = 1'b0;
        #2;
        chk("rr_oe_async", 32'(sda_oe), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        scl = 1'b1;
        wait_clk(Q);
        reset_n = 1'b1;
        wait_clk(Q);
        run_write(7'h50, 2, 8'h5A, 8'hE1, 1'b1);
        chk("rr_busy_after", 32'(busy), 32'd0);

        // randomized transactions against the transaction-level model
        for (int k = 0; k < 10; k++) begin
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
            rd = 1'($urandom);
            n  = $urandom_range(1, 3);
            if (rd) run_read(a, n, 8'($urandom), 8'($urandom), 1'b1);
            else    run_write(a, n, 8'($urandom), 8'($urandom), 1'b1);
            chk("rand_busy_idle", 32'(busy), 32'd0);
            chk("rand_oe_idle", 32'(sda_oe), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit address this target responds to.
REQ-002 Parameter SYNC_STAGES, default 2, flop depth of the SCL/SDA input synchronizers.
REQ-003 clk  input  1  single system clock; all logic is on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 scl_i  input  1  bus SCL level, asynchronous to clk.
REQ-006 sda_i  input  1  bus SDA level, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 rx_data  output  8  last byte written by the controller.
REQ-009 rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-010 tx_data  input  8  byte to return on a controller read.
REQ-011 tx_req  output  1  one-cycle pulse requesting the next tx_data.
REQ-012 rw  output  1  R/W bit of the current addressed transfer (1 = read).
REQ-013 busy  output  1  high from an address match until STOP or a non-matching repeated START.

Function
REQ-014 scl_i and sda_i SHALL pass through SYNC_STAGES flops; one further flop SHALL provide rise/fall detection, so events are seen SYNC_STAGES+1 clk after the pin changes.
REQ-015 Correct operation SHALL be guaranteed for clk >= 16x SCL frequency.
REQ-016 START SHALL be a synchronized SDA fall while synchronized SCL is high; STOP SHALL be an SDA rise while SCL is high.
REQ-017 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-018 START (including repeated START) from any state SHALL enter ADDR, clear the bit counter, and release sda_oe.
REQ-019 STOP from any state SHALL enter IDLE, release sda_oe, and clear busy.
REQ-020 Incoming bits SHALL be sampled on SCL rising edges, MSB first; sda_oe SHALL change only on detected SCL falling edges.
REQ-021 ADDR: after 8 bits (7 address + R/W), a match on the 8th SCL fall SHALL enter ADDR_ACK, drive sda_oe=1, set busy, and latch rw. A mismatch SHALL enter IGNORE with sda_oe=0.
REQ-022 ADDR_ACK: on the next SCL fall, go to WRITE (rw=0, sda_oe=0) or READ (rw=1, sda_oe=~tx_data[7]).
REQ-023 WRITE: on the 8th rising edge, rx_data SHALL update and rx_valid SHALL pulse one clk later. On the following fall, enter WRITE_ACK with sda_oe=1. On the next fall, release and return to WRITE. Every byte is ACKed.
REQ-024 tx_req SHALL pulse on the SCL rise of ADDR_ACK (read) and of each READ_ACK. tx_data SHALL be latched on the following SCL fall.
REQ-025 READ: sda_oe SHALL equal the inverted shift-register MSB, shifting on each SCL fall. After 8 bits, enter READ_ACK with sda_oe=0.
REQ-026 READ_ACK: controller ACK (SDA low at rise) SHALL return to READ with the new byte. NACK SHALL enter IGNORE.
REQ-027 IGNORE: sda_oe=0; leave only on START or STOP.
REQ-028 START or STOP mid-byte SHALL discard the partial byte, with no rx_valid and no tx_req.
REQ-029 Simultaneous START detection and an SCL edge SHALL resolve to START.

Reset
REQ-030 reset_n low SHALL immediately force state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, rw=0, busy=0, counter=0, and synchronizers=1 (idle bus).
REQ-031 Release mid-transfer SHALL wait in IDLE for the next START, ignoring the in-flight bits.

Structure
REQ-032 Package i2c_pkg SHALL hold the state enum i2c_slave_state_t, I2C_ADDR_W=7, and I2C_BYTE_W=8.
REQ-033 Sub-module i2c_sync_edge SHALL implement one synchronizer plus rise/fall pulses; it is instantiated twice (SCL, SDA).

Verification
REQ-034 Write 0x50+W, data 0xA5, 0x3C, STOP -> address ACKed; rx_valid twice with 0xA5 then 0x3C; each byte ACKed; busy low after STOP.
REQ-035 Read 0x50+R with tx_data=0x96, controller ACK, then 0x0F, NACK, STOP -> two tx_req pulses; bus bits 10010110, 00001111; IGNORE then IDLE.
REQ-036 Address 0x51 -> no ACK (SDA high on 9th clock), sda_oe stays 0, no rx_valid, busy=0.
REQ-037 Write 0x50 with 0x12, repeated START, read 0x50 -> rx_data=0x12, rw flips to 1, busy remains 1 throughout.
REQ-038 STOP after 4 data bits of a write -> no rx_valid; state IDLE; sda_oe=0.
REQ-039 reset_n pulse during a READ bit with sda_oe=1 -> sda_oe=0 asynchronously; next full write transfer succeeds.
